cadeado_controlador: RTL and testbench
======================================

Name: cadeado_controlador

Overview:
- Sequential combination-lock controller built around the 4-input cadeado lock.
- Inputs are four push-buttons a, b, c, d. The user keys a 4-digit code one press at a time; the block compares it to a stored code and drives aberto.
- Adds attempt counting, lockout, entry timeout, auto-relock and code reprogramming while open.
- Sits between the raw button inputs and the lock actuator / status LEDs.

Parameters:
- CODE_DEFAULT, 8'b00_01_10_11: code loaded at reset. Digit 0 is in bits [7:6], digit 3 in bits [1:0]. Default sequence is a, b, c, d.
- OPEN_CYCLES, 50: clock cycles aberto stays high before auto-relock.
- LOCKOUT_CYCLES, 200: clock cycles spent in lockout.
- TIMEOUT_CYCLES, 100: idle cycles allowed between digits before a partial entry is discarded.
- MAX_TENT, 3: consecutive wrong codes that trigger lockout (range 1..7).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- a  in  1  button, digit 0; level, high = pressed.
- b  in  1  button, digit 1.
- c  in  1  button, digit 2.
- d  in  1  button, digit 3.
- prog  in  1  request reprogramming; sampled only in ABERTO.
- aberto  out  1  lock open.
- bloqueado  out  1  lockout active.
- erro  out  1  one-cycle pulse on wrong code.
- tentativas  out  3  current count of consecutive wrong codes.
- digitos  out  3  digits collected so far in the current entry (0..4).

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - state=ENTRADA; code register=CODE_DEFAULT.
  - aberto, bloqueado, erro all 0; tentativas=0; digitos=0; all timers 0.
  - Button history registers load 4'b1111, so buttons held through reset do not register a press.
  - Reset mid-operation (open, lockout, programming) aborts immediately; any code programmed earlier is lost.
- Press detection:
  - press = {a,b,c,d} & ~history; history <= {a,b,c,d} every cycle.
  - Valid press: exactly one bit of press set. Digit encoding: a=0, b=1, c=2, d=3.
  - Multi-press: two or more bits set in the same cycle. It counts as one digit, and that digit is marked invalid.
- ENTRADA:
  - Each press stores its digit and increments digitos. The timeout timer clears on every press.
  - When digitos reaches 4, go to VERIFICA next cycle.
  - If digitos>0 and TIMEOUT_CYCLES cycles pass without a press: digitos=0, entry discarded, tentativas unchanged, no erro.
- VERIFICA (exactly 1 cycle):
  - Match (all 4 digits equal the code and none invalid): go to ABERTO; tentativas=0.
  - Otherwise: erro=1 for exactly the next cycle; tentativas+1.
    - If the new value equals MAX_TENT, go to BLOQUEIO; otherwise go to ENTRADA.
  - digitos clears to 0 on exit.
  - Presses arriving during VERIFICA are ignored.
- ABERTO:
  - aberto=1 starting the first cycle in the state, for OPEN_CYCLES cycles, then return to ENTRADA with aberto=0.
  - If prog=1 on any cycle here: go to PROGRAMA; aberto stays 1.
  - Presses here are ignored.
- PROGRAMA:
  - Collects 4 presses exactly as ENTRADA does.
  - All 4 valid: code register loads the new code on the cycle after the 4th press; go to ENTRADA with aberto=0.
  - Any multi-press, or a timeout: abort; code unchanged; go to ENTRADA with aberto=0.
  - No attempt counting here; no erro.
- BLOQUEIO:
  - bloqueado=1 for LOCKOUT_CYCLES cycles; all button and prog inputs ignored.
  - On exit: tentativas=0, bloqueado=0, go to ENTRADA.
- Counters: timers are sized with $clog2 of their parameter plus 1; they saturate and never wrap. tentativas never exceeds MAX_TENT.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan (bench uses OPEN_CYCLES=8, LOCKOUT_CYCLES=16, TIMEOUT_CYCLES=20, MAX_TENT=3):
- Correct code: reset, then single pulses a, b, c, d, each 2 cycles wide with 2 cycles gap.
  - Expect aberto=1 starting 2 cycles after the d edge, held exactly 8 cycles; tentativas=0; erro never high.
- Wrong code: press d, c, b, a.
  - Expect erro high exactly 1 cycle; tentativas=1; aberto stays 0; digitos back to 0.
- Lockout: 3 wrong codes.
  - Expect tentativas 1→2→3, then bloqueado=1 for 16 cycles; a correct code entered during lockout is ignored; after lockout tentativas=0.
  - A correct code entered after lockout opens the lock.
- Timeout and multi-press:
  - Press a, b, then idle 20 cycles → digitos=0, no erro, tentativas unchanged.
  - Press a and b together, then c, d, a → erro=1, tentativas=1.
- Reprogramming:
  - Open with a, b, c, d; raise prog; press d, d, a, a → aberto drops after the 4th press.
  - Old code a, b, c, d now gives erro; d, d, a, a opens.
  - Pulse rst_n=0 → code returns to a, b, c, d.
- Reset mid-operation:
  - rst_n low during ABERTO, or during BLOQUEIO with tentativas=3 → next cycle all outputs 0.
  - A button held through reset does not count as a press.

Source files
------------

// File: rtl/cadeado_controlador.sv
// Combination-lock controller: collects a 4-digit code from four push-buttons,
// compares it to a stored code and drives the open / lockout / error outputs.
// Also handles attempt counting, lockout, entry timeout, auto-relock and
// reprogramming of the code while the lock is open.
module cadeado_controlador #(
  parameter logic [7:0] CODE_DEFAULT   = 8'b00_01_10_11,
  parameter int         OPEN_CYCLES    = 50,
  parameter int         LOCKOUT_CYCLES = 200,
  parameter int         TIMEOUT_CYCLES = 100,
  parameter int         MAX_TENT       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       prog,
  output logic       aberto,
  output logic       bloqueado,
  output logic       erro,
  output logic [2:0] tentativas,
  output logic [2:0] digitos
);

  // One timer is shared by all states; it is sized for the largest interval.
  localparam int TMAX_AB = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TMAX    = (TMAX_AB > TIMEOUT_CYCLES) ? TMAX_AB : TIMEOUT_CYCLES;
  localparam int TW      = $clog2(TMAX) + 1;

  typedef logic [TW-1:0] tmr_t;

  localparam tmr_t       OPEN_LAST = tmr_t'(OPEN_CYCLES - 1);
  localparam tmr_t       LOCK_LAST = tmr_t'(LOCKOUT_CYCLES - 1);
  localparam tmr_t       TO_LAST   = tmr_t'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] TENT_MAX  = 3'(MAX_TENT);

  typedef enum logic [2:0] {
    ENTRADA, VERIFICA, ABERTO, PROGRAMA, BLOQUEIO
  } state_t;

  state_t     state, nxt_state;
  logic [3:0] hist;
  logic [7:0] code, nxt_code;
  logic [7:0] dbuf, nxt_dbuf;
  logic       inv, nxt_inv;
  tmr_t       tmr, nxt_tmr, tmr_inc;
  logic       nxt_aberto, nxt_bloq, nxt_erro;
  logic [2:0] nxt_tent, nxt_dig, tent_inc;

  logic [3:0] btn, press;
  logic       any_press, multi;
  logic [1:0] dig;

  // Rising-edge detect on the buttons; a=bit3 maps to digit 0.
  assign btn       = {a, b, c, d};
  assign press     = btn & ~hist;
  assign any_press = |press;
  assign multi     = (press & (press - 4'd1)) != 4'd0;
  assign tmr_inc   = (tmr == {TW{1'b1}}) ? tmr : tmr + tmr_t'(1);
  assign tent_inc  = tentativas + 3'd1;

  // Encode the single pressed button; multi-press digits are flagged invalid.
  always_comb begin
    dig = 2'd0;
    case (press)
      4'b1000: dig = 2'd0;
      4'b0100: dig = 2'd1;
      4'b0010: dig = 2'd2;
      4'b0001: dig = 2'd3;
      default: dig = 2'd0;
    endcase
  end

  // Next-state and next-output logic for the lock FSM.
  always_comb begin
    nxt_state  = state;
    nxt_code   = code;
    nxt_dbuf   = dbuf;
    nxt_inv    = inv;
    nxt_tmr    = tmr;
    nxt_aberto = aberto;
    nxt_bloq   = bloqueado;
    nxt_erro   = 1'b0;
    nxt_tent   = tentativas;
    nxt_dig    = digitos;
    case (state)
      ENTRADA: begin
        if (digitos == 3'd4) begin
          nxt_state = VERIFICA;
        end else if (any_press) begin
          nxt_dbuf = {dbuf[5:0], dig};
          nxt_inv  = inv | multi;
          nxt_dig  = digitos + 3'd1;
          nxt_tmr  = '0;
        end else if (digitos != 3'd0) begin
          // Partial entry left idle too long is silently discarded.
          if (tmr >= TO_LAST) begin
            nxt_dig = 3'd0;
            nxt_inv = 1'b0;
            nxt_tmr = '0;
          end else begin
            nxt_tmr = tmr_inc;
          end
        end
      end
      VERIFICA: begin
        nxt_dig = 3'd0;
        nxt_inv = 1'b0;
        nxt_tmr = '0;
        if (!inv && dbuf == code) begin
          nxt_state  = ABERTO;
          nxt_aberto = 1'b1;
          nxt_tent   = 3'd0;
        end else begin
          nxt_erro = 1'b1;
          if (tent_inc >= TENT_MAX) begin
            nxt_tent  = TENT_MAX;
            nxt_state = BLOQUEIO;
            nxt_bloq  = 1'b1;
          end else begin
            nxt_tent  = tent_inc;
            nxt_state = ENTRADA;
          end
        end
      end
      ABERTO: begin
        if (prog) begin
          nxt_state = PROGRAMA;
          nxt_tmr   = '0;
          nxt_dig   = 3'd0;
          nxt_inv   = 1'b0;
        end else if (tmr >= OPEN_LAST) begin
          nxt_state  = ENTRADA;
          nxt_aberto = 1'b0;
          nxt_tmr    = '0;
        end else begin
          nxt_tmr = tmr_inc;
        end
      end
      PROGRAMA: begin
        // Every exit closes the lock; only a clean 4-digit entry updates the code.
        if (digitos == 3'd4) begin
          nxt_code   = dbuf;
          nxt_state  = ENTRADA;
          nxt_aberto = 1'b0;
          nxt_dig    = 3'd0;
          nxt_tmr    = '0;
        end else if (any_press && !multi) begin
          nxt_dbuf = {dbuf[5:0], dig};
          nxt_dig  = digitos + 3'd1;
          nxt_tmr  = '0;
        end else if (multi || tmr >= TO_LAST) begin
          nxt_state  = ENTRADA;
          nxt_aberto = 1'b0;
          nxt_dig    = 3'd0;
          nxt_tmr    = '0;
        end else begin
          nxt_tmr = tmr_inc;
        end
      end
      BLOQUEIO: begin
        if (tmr >= LOCK_LAST) begin
          nxt_state = ENTRADA;
          nxt_bloq  = 1'b0;
          nxt_tent  = 3'd0;
          nxt_tmr   = '0;
        end else begin
          nxt_tmr = tmr_inc;
        end
      end
      default: begin
        nxt_state  = ENTRADA;
        nxt_aberto = 1'b0;
        nxt_bloq   = 1'b0;
        nxt_dig    = 3'd0;
        nxt_tmr    = '0;
      end
    endcase
  end

  // State and output registers; history reset high so held buttons are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ENTRADA;
      code       <= CODE_DEFAULT;
      dbuf       <= 8'd0;
      inv        <= 1'b0;
      tmr        <= '0;
      hist       <= 4'b1111;
      aberto     <= 1'b0;
      bloqueado  <= 1'b0;
      erro       <= 1'b0;
      tentativas <= 3'd0;
      digitos    <= 3'd0;
    end else begin
      state      <= nxt_state;
      code       <= nxt_code;
      dbuf       <= nxt_dbuf;
      inv        <= nxt_inv;
      tmr        <= nxt_tmr;
      hist       <= btn;
      aberto     <= nxt_aberto;
      bloqueado  <= nxt_bloq;
      erro       <= nxt_erro;
      tentativas <= nxt_tent;
      digitos    <= nxt_dig;
    end
  end

endmodule

// File: tb/tb_cadeado_controlador.sv
// Directed bench for cadeado_controlador: open, wrong code, lockout,
// timeout, multi-press, reprogramming and reset in the middle of operation.
module tb_cadeado_controlador;

  localparam logic [3:0] KA = 4'b1000;
  localparam logic [3:0] KB = 4'b0100;
  localparam logic [3:0] KC = 4'b0010;
  localparam logic [3:0] KD = 4'b0001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic       prog;
  logic       aberto, bloqueado, erro;
  logic [2:0] tentativas, digitos;

  int cmp_n = 0;
  int bad_n = 0;
  int erro_n = 0, ab_n = 0, bl_n = 0;
  int e0, a0, b0;

  cadeado_controlador #(
    .CODE_DEFAULT  (8'b00_01_10_11),
    .OPEN_CYCLES   (8),
    .LOCKOUT_CYCLES(16),
    .TIMEOUT_CYCLES(20),
    .MAX_TENT      (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (btn[3]),
    .b         (btn[2]),
    .c         (btn[1]),
    .d         (btn[0]),
    .prog      (prog),
    .aberto    (aberto),
    .bloqueado (bloqueado),
    .erro      (erro),
    .tentativas(tentativas),
    .digitos   (digitos)
  );

  always #5 clk = ~clk;

  // Cycle counters of the status outputs, sampled at the falling edge.
  always @(negedge clk) begin
    if (erro)      erro_n <= erro_n + 1;
    if (aberto)    ab_n   <= ab_n + 1;
    if (bloqueado) bl_n   <= bl_n + 1;
  end

  task automatic push(input logic [3:0] m, input int w);
    btn = m;
    repeat (w) @(negedge clk);
    btn = 4'b0000;
    repeat (w) @(negedge clk);
  endtask

  task automatic enter(input logic [3:0] m0, input logic [3:0] m1,
                       input logic [3:0] m2, input logic [3:0] m3);
    push(m0, 2); push(m1, 2); push(m2, 2); push(m3, 2);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn = 4'b0000; prog = 1'b0;
    repeat (3) @(negedge clk);
    cmp_n++; if (aberto !== 1'b0) begin bad_n++; $display("FAIL rst_aberto: got %b want 0", aberto); end
    cmp_n++; if (bloqueado !== 1'b0) begin bad_n++; $display("FAIL rst_bloq: got %b want 0", bloqueado); end
    cmp_n++; if (erro !== 1'b0) begin bad_n++; $display("FAIL rst_erro: got %b want 0", erro); end
    cmp_n++; if (tentativas !== 3'd0) begin bad_n++; $display("FAIL rst_tent: got %0d want 0", tentativas); end
    cmp_n++; if (digitos !== 3'd0) begin bad_n++; $display("FAIL rst_dig: got %0d want 0", digitos); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_correct_code();
    e0 = erro_n; a0 = ab_n;
    push(KA, 2); push(KB, 2); push(KC, 2);
    cmp_n++; if (digitos !== 3'd3) begin bad_n++; $display("FAIL co_dig3: got %0d want 3", digitos); end
    btn = KD;
    @(negedge clk);
    cmp_n++; if (digitos !== 3'd4) begin bad_n++; $display("FAIL co_dig4: got %0d want 4", digitos); end
    cmp_n++; if (aberto !== 1'b0) begin bad_n++; $display("FAIL co_lat1: aberto got %b want 0", aberto); end
    @(negedge clk);
    cmp_n++; if (aberto !== 1'b0) begin bad_n++; $display("FAIL co_lat2: aberto got %b want 0", aberto); end
    btn = 4'b0000;
    @(negedge clk);
    cmp_n++; if (aberto !== 1'b1) begin bad_n++; $display("FAIL co_open: aberto got %b want 1", aberto); end
    cmp_n++; if (tentativas !== 3'd0) begin bad_n++; $display("FAIL co_tent: got %0d want 0", tentativas); end
    repeat (7) @(negedge clk);
    cmp_n++; if (aberto !== 1'b1) begin bad_n++; $display("FAIL co_last: aberto got %b want 1", aberto); end
    @(negedge clk);
    cmp_n++; if (aberto !== 1'b0) begin bad_n++; $display("FAIL co_relock: aberto got %b want 0", aberto); end
    cmp_n++; if (ab_n - a0 !== 8) begin bad_n++; $display("FAIL co_open_len: got %0d want 8", ab_n - a0); end
    cmp_n++; if (erro_n - e0 !== 0) begin bad_n++; $display("FAIL co_noerro: got %0d want 0", erro_n - e0); end
  endtask

  task automatic test_wrong_code();
    e0 = erro_n; a0 = ab_n;
    enter(KD, KC, KB, KA);
    cmp_n++; if (erro_n - e0 !== 1) begin bad_n++; $display("FAIL wr_erro_len: got %0d want 1", erro_n - e0); end
    cmp_n++; if (tentativas !== 3'd1) begin bad_n++; $display("FAIL wr_tent: got %0d want 1", tentativas); end
    cmp_n++; if (digitos !== 3'd0) begin bad_n++; $display("FAIL wr_dig: got %0d want 0", digitos); end
    cmp_n++; if (ab_n - a0 !== 0) begin bad_n++; $display("FAIL wr_noopen: got %0d want 0", ab_n - a0); end
  endtask

  task automatic test_lockout();
    pulse_reset();
    enter(KD, KC, KB, KA);
    cmp_n++; if (tentativas !== 3'd1) begin bad_n++; $display("FAIL lk_t1: got %0d want 1", tentativas); end
    enter(KB, KB, KB, KB);
    cmp_n++; if (tentativas !== 3'd2) begin bad_n++; $display("FAIL lk_t2: got %0d want 2", tentativas); end
    b0 = bl_n; a0 = ab_n;
    enter(KC, KC, KC, KC);
    cmp_n++; if (tentativas !== 3'd3) begin bad_n++; $display("FAIL lk_t3: got %0d want 3", tentativas); end
    cmp_n++; if (bloqueado !== 1'b1) begin bad_n++; $display("FAIL lk_bloq: got %b want 1", bloqueado); end
    // Correct code keyed quickly while locked out must be ignored.
    push(KA, 1); push(KB, 1); push(KC, 1); push(KD, 1);
    cmp_n++; if (digitos !== 3'd0) begin bad_n++; $display("FAIL lk_ign_dig: got %0d want 0", digitos); end
    cmp_n++; if (bloqueado !== 1'b1) begin bad_n++; $display("FAIL lk_still: got %b want 1", bloqueado); end
    repeat (6) @(negedge clk);
    cmp_n++; if (bloqueado !== 1'b1) begin bad_n++; $display("FAIL lk_last: got %b want 1", bloqueado); end
    @(negedge clk);
    cmp_n++; if (bloqueado !== 1'b0) begin bad_n++; $display("FAIL lk_exit: got %b want 0", bloqueado); end
    cmp_n++; if (tentativas !== 3'd0) begin bad_n++; $display("FAIL lk_tclr: got %0d want 0", tentativas); end
    cmp_n++; if (bl_n - b0 !== 16) begin bad_n++; $display("FAIL lk_len: got %0d want 16", bl_n - b0); end
    cmp_n++; if (ab_n - a0 !== 0) begin bad_n++; $display("FAIL lk_noopen: got %0d want 0", ab_n - a0); end
    enter(KA, KB, KC, KD);
    cmp_n++; if (aberto !== 1'b1) begin bad_n++; $display("FAIL lk_after_open: got %b want 1", aberto); end
    repeat (7) @(negedge clk);
    cmp_n++; if (aberto !== 1'b0) begin bad_n++; $display("FAIL lk_relock: got %b want 0", aberto); end
  endtask

  task automatic test_timeout();
    e0 = erro_n;
    push(KA, 2); push(KB, 2);
    cmp_n++; if (digitos !== 3'd2) begin bad_n++; $display("FAIL to_dig2: got %0d want 2", digitos); end
    repeat (16) @(negedge clk);
    cmp_n++; if (digitos !== 3'd2) begin bad_n++; $display("FAIL to_before: got %0d want 2", digitos); end
    @(negedge clk);
    cmp_n++; if (digitos !== 3'd0) begin bad_n++; $display("FAIL to_clear: got %0d want 0", digitos); end
    cmp_n++; if (tentativas !== 3'd0) begin bad_n++; $display("FAIL to_tent: got %0d want 0", tentativas); end
    cmp_n++; if (erro_n - e0 !== 0) begin bad_n++; $display("FAIL to_noerro: got %0d want 0", erro_n - e0); end
  endtask

  task automatic test_multipress();
    e0 = erro_n;
    push(KA | KB, 2);
    cmp_n++; if (digitos !== 3'd1) begin bad_n++; $display("FAIL mp_dig1: got %0d want 1", digitos); end
    push(KC, 2); push(KD, 2); push(KA, 2);
    cmp_n++; if (erro_n - e0 !== 1) begin bad_n++; $display("FAIL mp_erro: got %0d want 1", erro_n - e0); end
    cmp_n++; if (tentativas !== 3'd1) begin bad_n++; $display("FAIL mp_tent: got %0d want 1", tentativas); end
    cmp_n++; if (aberto !== 1'b0) begin bad_n++; $display("FAIL mp_aberto: got %b want 0", aberto); end
  endtask

  task automatic test_reprogram();
    enter(KA, KB, KC, KD);
    cmp_n++; if (aberto !== 1'b1) begin bad_n++; $display("FAIL pg_open: got %b want 1", aberto); end
    cmp_n++; if (tentativas !== 3'd0) begin bad_n++; $display("FAIL pg_tent0: got %0d want 0", tentativas); end
    prog = 1'b1;
    @(negedge clk);
    prog = 1'b0;
    cmp_n++; if (aberto !== 1'b1) begin bad_n++; $display("FAIL pg_hold: got %b want 1", aberto); end
    push(KD, 2); push(KD, 2); push(KA, 2);
    cmp_n++; if (aberto !== 1'b1) begin bad_n++; $display("FAIL pg_mid: got %b want 1", aberto); end
    btn = KA;
    @(negedge clk);
    cmp_n++; if (aberto !== 1'b1) begin bad_n++; $display("FAIL pg_4th: got %b want 1", aberto); end
    @(negedge clk);
    cmp_n++; if (aberto !== 1'b0) begin bad_n++; $display("FAIL pg_close: got %b want 0", aberto); end
    btn = 4'b0000;
    repeat (2) @(negedge clk);
    e0 = erro_n;
    enter(KA, KB, KC, KD);
    cmp_n++; if (erro_n - e0 !== 1) begin bad_n++; $display("FAIL pg_old_erro: got %0d want 1", erro_n - e0); end
    cmp_n++; if (aberto !== 1'b0) begin bad_n++; $display("FAIL pg_old_shut: got %b want 0", aberto); end
    enter(KD, KD, KA, KA);
    cmp_n++; if (aberto !== 1'b1) begin bad_n++; $display("FAIL pg_new_open: got %b want 1", aberto); end
    repeat (7) @(negedge clk);
    pulse_reset();
    enter(KA, KB, KC, KD);
    cmp_n++; if (aberto !== 1'b1) begin bad_n++; $display("FAIL pg_default_back: got %b want 1", aberto); end
  endtask

  task automatic test_reset_mid();
    // Lock is open on entry here.
    rst_n = 1'b0;
    @(negedge clk);
    cmp_n++; if (aberto !== 1'b0) begin bad_n++; $display("FAIL rm_ab_aberto: got %b want 0", aberto); end
    cmp_n++; if (digitos !== 3'd0) begin bad_n++; $display("FAIL rm_ab_dig: got %0d want 0", digitos); end
    rst_n = 1'b1;
    @(negedge clk);
    enter(KB, KB, KB, KB); enter(KB, KB, KB, KB); enter(KB, KB, KB, KB);
    cmp_n++; if (tentativas !== 3'd3) begin bad_n++; $display("FAIL rm_pre_t: got %0d want 3", tentativas); end
    cmp_n++; if (bloqueado !== 1'b1) begin bad_n++; $display("FAIL rm_pre_b: got %b want 1", bloqueado); end
    rst_n = 1'b0;
    @(negedge clk);
    cmp_n++; if (bloqueado !== 1'b0) begin bad_n++; $display("FAIL rm_bl_bloq: got %b want 0", bloqueado); end
    cmp_n++; if (tentativas !== 3'd0) begin bad_n++; $display("FAIL rm_bl_tent: got %0d want 0", tentativas); end
    cmp_n++; if (erro !== 1'b0) begin bad_n++; $display("FAIL rm_bl_erro: got %b want 0", erro); end
    cmp_n++; if (aberto !== 1'b0) begin bad_n++; $display("FAIL rm_bl_aberto: got %b want 0", aberto); end
    // Button held through reset release must not register.
    btn = KA;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cmp_n++; if (digitos !== 3'd0) begin bad_n++; $display("FAIL rm_held: got %0d want 0", digitos); end
    btn = 4'b0000;
    @(negedge clk);
    push(KB, 2);
    cmp_n++; if (digitos !== 3'd1) begin bad_n++; $display("FAIL rm_next: got %0d want 1", digitos); end
  endtask

  initial begin
    rst_n = 1'b0; btn = 4'b0000; prog = 1'b0;
    test_reset();
    test_correct_code();
    test_wrong_code();
    test_lockout();
    test_timeout();
    test_multipress();
    test_reprogram();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule
